window_pointer_ctrl: RTL and testbench

WINDOW_POINTER_CTRL -- requirements
Module: window_pointer_ctrl

---
 rtl/window_pointer_ctrl_pkg.sv | 35 +++
 rtl/window_pointer_ctrl_decoder_2x4.sv | 19 +
 rtl/window_pointer_ctrl.sv | 122 ++++++++++++
 tb/tb_window_pointer_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_pointer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : window_pkg
//  Purpose  : Shared encodings for the register-window pointer controller:
//             operation codes, FSM states, window count and trap types.
//  Revision : 1.0  initial release
// ============================================================================
package window_pkg;

  localparam int         WIN_NWINDOWS = 4;
  localparam logic [7:0] WIN_TT_OVF   = 8'h05;
  localparam logic [7:0] WIN_TT_UNF   = 8'h06;

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_SAVE       = 3'd1;
  localparam logic [2:0] OP_RESTORE    = 3'd2;
  localparam logic [2:0] OP_TRAP_ENTER = 3'd3;
  localparam logic [2:0] OP_RETT       = 3'd4;
  localparam logic [2:0] OP_WR_CWP     = 3'd5;
  localparam logic [2:0] OP_WR_WIM     = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_TRAP   = 2'd3
  } state_t;

  // Code 7 is unassigned and behaves exactly like NOP.
  function automatic logic op_is_nop(input logic [2:0] o);
    return (o == OP_NOP) || (o == 3'd7);
  endfunction

endpackage
`default_nettype wire

// File: rtl/window_pointer_ctrl_decoder_2x4.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_2x4
//  Purpose  : 2-to-4 one-hot decoder with an active-high enable; all outputs
//             are zero while the enable is low.
//  Revision : 1.0  initial release
// ============================================================================
module decoder_2x4 (
  input  logic [1:0] in,
  input  logic       enable,
  output logic [3:0] out
);

  for (genvar i = 0; i < 4; i++) begin : g_dec
    assign out[i] = enable && (in == 2'(i));
  end

endmodule
`default_nettype wire

// File: rtl/window_pointer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : window_pointer_ctrl
//  Purpose  : Current-window-pointer / window-invalid-mask controller.
//             Each accepted op runs IDLE -> CHECK -> COMMIT (or TRAP) and the
//             architectural cwp/wim only change on the COMMIT edge.
//  Revision : 1.0  initial release
// ============================================================================
module window_pointer_ctrl
  import window_pkg::*;
#(
  parameter int         NWINDOWS = WIN_NWINDOWS,  // only 4 is supported
  parameter logic [7:0] TT_OVF   = WIN_TT_OVF,
  parameter logic [7:0] TT_UNF   = WIN_TT_UNF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [2:0] op,
  input  logic [3:0] wr_data,
  output logic [1:0] cwp,
  output logic [3:0] wim,
  output logic [3:0] window_sel,
  output logic       trap_valid,
  output logic [7:0] trap_type,
  input  logic       trap_ack
);

  localparam logic [1:0] C_CWP_MAX = 2'(NWINDOWS - 1);

  state_t     r_state;
  logic [2:0] r_op;
  logic [3:0] r_wr_data;
  logic [1:0] r_new_cwp;
  logic       r_dec_en;

  logic [1:0] w_new_cwp;
  logic       w_ovf;
  logic       w_unf;

  assign op_ready = (r_state == ST_IDLE);

  // Candidate pointer for the latched op, plus the wim-based trap tests.
  // Only SAVE/RESTORE/RETT consult wim; the other ops never trap.
  always_comb begin
    w_new_cwp = cwp;
    case (r_op)
      OP_SAVE, OP_TRAP_ENTER: w_new_cwp = (cwp == 2'd0) ? C_CWP_MAX : cwp - 2'd1;
      OP_RESTORE, OP_RETT:    w_new_cwp = (cwp == C_CWP_MAX) ? 2'd0 : cwp + 2'd1;
      OP_WR_CWP:              w_new_cwp = r_wr_data[1:0];
      default:                w_new_cwp = cwp;
    endcase
    w_ovf = (r_op == OP_SAVE) && wim[w_new_cwp];
    w_unf = ((r_op == OP_RESTORE) || (r_op == OP_RETT)) && wim[w_new_cwp];
  end

  // Control FSM with registered outputs. The decode enable is cleared on the
  // accept edge and set again on the edge that returns to IDLE, which is the
  // same edge that writes cwp, so window_sel never shows a stale pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_NOP;
      r_wr_data  <= 4'd0;
      r_new_cwp  <= 2'd0;
      r_dec_en   <= 1'b0;
      cwp        <= 2'd0;
      wim        <= 4'd0;
      trap_valid <= 1'b0;
      trap_type  <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_dec_en <= 1'b1;
          if (op_valid && !op_is_nop(op)) begin
            r_op      <= op;
            r_wr_data <= wr_data;
            r_dec_en  <= 1'b0;
            r_state   <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          r_new_cwp <= w_new_cwp;
          if (w_ovf || w_unf) begin
            trap_valid <= 1'b1;
            trap_type  <= w_ovf ? TT_OVF : TT_UNF;
            r_state    <= ST_TRAP;
          end else begin
            r_state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          if (r_op == OP_WR_WIM) begin
            wim <= r_wr_data;
          end else begin
            cwp <= r_new_cwp;
          end
          r_dec_en <= 1'b1;
          r_state  <= ST_IDLE;
        end
        ST_TRAP: begin
          if (trap_ack) begin
            trap_valid <= 1'b0;
            trap_type  <= 8'd0;
            r_dec_en   <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  decoder_2x4 u_decoder (
    .in     (cwp),
    .enable (r_dec_en),
    .out    (window_sel)
  );

endmodule
`default_nettype wire

// File: tb/tb_window_pointer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_window_pointer_ctrl
//  Purpose  : Randomized scoreboard bench for window_pointer_ctrl. The driver
//             computes each op's outcome from the window rules and queues it;
//             the monitor pops and compares when the DUT returns to IDLE.
//  Revision : 1.0  initial release
// ============================================================================
module tb_window_pointer_ctrl;

  localparam int NW = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] op;
  logic [3:0] wr_data;
  logic [1:0] cwp;
  logic [3:0] wim;
  logic [3:0] window_sel;
  logic       trap_valid;
  logic [7:0] trap_type;
  logic       trap_ack;

  window_pointer_ctrl #(.NWINDOWS(4), .TT_OVF(8'h05), .TT_UNF(8'h06)) dut (
    .clk        (clk),
    .reset      (reset),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op         (op),
    .wr_data    (wr_data),
    .cwp        (cwp),
    .wim        (wim),
    .window_sel (window_sel),
    .trap_valid (trap_valid),
    .trap_type  (trap_type),
    .trap_ack   (trap_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       trap;
    logic [7:0] tt;
    logic [1:0] cwp;
    logic [3:0] wim;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference state, updated when an op is issued.
  int         m_cwp = 0;
  logic [3:0] m_wim = 4'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Window rules: SAVE/TRAP_ENTER move down, RESTORE/RETT move up (mod NW);
  // SAVE into an invalid window overflows, RESTORE/RETT underflow.
  task automatic model_push(input logic [2:0] o, input logic [3:0] d);
    exp_t e;
    int   n;
    e.trap = 1'b0;
    e.tt   = 8'h00;
    case (o)
      3'd1: begin
        n = (m_cwp + NW - 1) % NW;
        if (m_wim[n]) begin e.trap = 1'b1; e.tt = 8'h05; end
        else m_cwp = n;
      end
      3'd2, 3'd4: begin
        n = (m_cwp + 1) % NW;
        if (m_wim[n]) begin e.trap = 1'b1; e.tt = 8'h06; end
        else m_cwp = n;
      end
      3'd3: m_cwp = (m_cwp + NW - 1) % NW;
      3'd5: m_cwp = int'(d) % NW;
      3'd6: m_wim = d;
      default: ;
    endcase
    e.cwp = 2'(m_cwp);
    e.wim = m_wim;
    if (o != 3'd0 && o != 3'd7) exp_q.push_back(e);
  endtask

  // Wait for IDLE (holding op_valid with junk while busy, poking trap_ack),
  // then present one op for one clock.
  task automatic do_op(input logic [2:0] o, input logic [3:0] d);
    int guard = 0;
    while (!op_ready && guard < 200) begin
      op_valid = 1'b1;
      op       = 3'($urandom);
      wr_data  = 4'($urandom);
      trap_ack = trap_valid ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: got op_ready=%0b, expected 1 within 200 cycles", op_ready);
    end
    trap_ack = 1'($urandom_range(0, 1));
    op_valid = 1'b1;
    op       = o;
    wr_data  = d;
    model_push(o, d);
    @(negedge clk);
    op_valid = 1'b0;
    trap_ack = 1'b0;
  endtask

  // Monitor: samples just after each falling edge.
  initial begin : monitor
    logic       prev_ready;
    logic       saw_trap;
    logic       ack_pend;
    logic       hold_pend;
    logic [7:0] tt_seen;
    logic [1:0] last_cwp;
    logic [3:0] last_wim;
    int         busy;
    exp_t       e;
    prev_ready = 1'b1; saw_trap = 1'b0; ack_pend = 1'b0; hold_pend = 1'b0;
    tt_seen = 8'd0; last_cwp = 2'd0; last_wim = 4'd0; busy = 0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        exp_q.delete();
        prev_ready = 1'b1; saw_trap = 1'b0; ack_pend = 1'b0; hold_pend = 1'b0;
        last_cwp = 2'd0; last_wim = 4'd0; busy = 0;
        continue;
      end
      if (ack_pend)  chk("ack_to_idle", {30'd0, trap_valid, op_ready}, 32'd1);
      if (hold_pend) chk("trap_hold", {31'd0, trap_valid}, 32'd1);
      ack_pend  = 1'b0;
      hold_pend = 1'b0;
      if (!op_ready) begin
        busy++;
        chk("busy_sel_zero", {28'd0, window_sel}, 32'd0);
        chk("busy_cwp_stable", {30'd0, cwp}, {30'd0, last_cwp});
        chk("busy_wim_stable", {28'd0, wim}, {28'd0, last_wim});
        if (trap_valid) begin
          saw_trap = 1'b1;
          tt_seen  = trap_type;
          if (trap_ack) ack_pend = 1'b1;
          else          hold_pend = 1'b1;
        end
        if (busy > 64) begin
          chk("busy_timeout", busy, 32'd64);
          busy = 0;
        end
      end else if (!prev_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("trap_flag", {31'd0, saw_trap}, {31'd0, e.trap});
          if (e.trap) chk("trap_type", {24'd0, tt_seen}, {24'd0, e.tt});
          else        chk("latency", busy, 32'd2);
          chk("cwp", {30'd0, cwp}, {30'd0, e.cwp});
          chk("wim", {28'd0, wim}, {28'd0, e.wim});
          chk("window_sel", {28'd0, window_sel}, {28'd0, 4'b0001 << e.cwp});
          chk("idle_trap_clear", {23'd0, trap_valid, trap_type}, 32'd0);
          last_cwp = e.cwp;
          last_wim = e.wim;
        end
        busy     = 0;
        saw_trap = 1'b0;
      end
      prev_ready = op_ready;
    end
  end

  // Stimulus
  initial begin : driver
    reset = 1'b1; op_valid = 1'b0; op = 3'd0; wr_data = 4'd0; trap_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cwp", {30'd0, cwp}, 32'd0);
    chk("rst_wim", {28'd0, wim}, 32'd0);
    chk("rst_sel", {28'd0, window_sel}, 32'd0);
    chk("rst_trap", {23'd0, trap_valid, trap_type}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_sel_zero", {28'd0, window_sel}, 32'd0);
    chk("rel_ready", {31'd0, op_ready}, 32'd1);
    @(negedge clk);
    chk("rel_sel_one", {28'd0, window_sel}, 32'd1);

    // SAVE x4 with wim clear: 3,2,1,0
    repeat (4) do_op(3'd1, 4'd0);
    // overflow trap at cwp 0
    do_op(3'd6, 4'b1000);
    do_op(3'd1, 4'd0);
    // underflow via RESTORE and RETT wrapping 3 -> 0
    do_op(3'd6, 4'b0001);
    do_op(3'd5, 4'd3);
    do_op(3'd2, 4'd0);
    do_op(3'd4, 4'd0);
    // TRAP_ENTER ignores wim
    do_op(3'd6, 4'b1111);
    do_op(3'd5, 4'd0);
    do_op(3'd3, 4'd0);
    // NOP and code 7 leave everything alone
    do_op(3'd0, 4'd5);
    do_op(3'd7, 4'd2);
    do_op(3'd5, 4'd2);

    // Random traffic
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) begin
        op_valid = 1'b0;
        trap_ack = trap_valid;
        @(negedge clk);
      end
      do_op(3'($urandom_range(0, 7)), 4'($urandom));
    end

    // Reset during COMMIT of WR_CWP 2'b10
    do_op(3'd6, 4'b0110);
    do_op(3'd5, 4'd1);
    do_op(3'd5, 4'd2);
    @(negedge clk);
    #2;
    reset = 1'b1;
    m_cwp = 0;
    m_wim = 4'd0;
    #1;
    chk("midrst_cwp", {30'd0, cwp}, 32'd0);
    chk("midrst_wim", {28'd0, wim}, 32'd0);
    chk("midrst_sel", {28'd0, window_sel}, 32'd0);
    chk("midrst_trap", {23'd0, trap_valid, trap_type}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_rel_sel", {28'd0, window_sel}, 32'd0);
    @(negedge clk);
    #1;
    chk("midrst_sel_one", {28'd0, window_sel}, 32'd1);
    @(negedge clk);

    // A few ops after the mid-operation reset
    do_op(3'd2, 4'd0);
    do_op(3'd1, 4'd0);
    do_op(3'd6, 4'b0010);
    do_op(3'd2, 4'd0);

    // Drain outstanding expectations
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      op_valid = 1'b0;
      trap_ack = trap_valid;
      @(negedge clk);
    end
    @(negedge clk);
    #2;
    chk("drain_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
